// File: rtl/text_pkg.sv
// text_pkg: shared constants, FSM state type and cell address helper for the text console.
package text_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam int X_MAX = 640;
  localparam int Y_MAX = 480;
  localparam int BUF_DEPTH = 2400;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int HB = $clog2(CHAR_W);
  localparam int VB = $clog2(CHAR_H);
  typedef enum logic {CLEAR, RUN} state_t;
  function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return ({6'd0, row} << 6) + ({6'd0, row} << 4) + {5'd0, col};
  endfunction
endpackage

// File: rtl/char_lut.sv
// char_lut: combinational character look-up table, MSB of each glyph row is the leftmost pixel.
module char_lut (
  input  logic [7:0] ch,
  input  logic [3:0] vidx,
  input  logic [2:0] hidx,
  output logic       lit
);
  localparam logic [127:0] GLYPH_A = 128'h0000_1028_4482_82FE_8282_8282_0000_0000;
  localparam logic [127:0] GLYPH_Q = 128'h0000_0000_0000_3E42_4242_423E_0202_0200;
  logic [6:0] base;
  logic [7:0] bits;
  always_comb begin
    base = 7'd127 - {vidx, 3'b000};
    bits = ch == 8'h41 ? GLYPH_A[base -: 8] : ch == 8'h71 ? GLYPH_Q[base -: 8] : 8'h00;
    lit = bits[3'd7 - hidx];
  end
endmodule

// File: rtl/text_buffer.sv
// text_buffer: 2400x8 simple dual-port synchronous RAM, read-first, contents not reset.
module text_buffer
  import text_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [7:0]  wdata,
  input  logic        re,
  input  logic [11:0] raddr,
  output logic [7:0]  rdata
);
  logic [7:0] mem [BUF_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/text_renderer.sv
// text_renderer: 80x30 text console pixel stage; buffer read in stage 1, glyph lookup and colour mux in stage 2.
module text_renderer
  import text_pkg::*;
#(
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_active,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        wr_en,
  input  logic [6:0]  wr_col,
  input  logic [4:0]  wr_row,
  input  logic [7:0]  wr_char,
  output logic        wr_ready,
  output logic        busy,
  output logic [11:0] out_rgb,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_active
);
  state_t state_q, state_d;
  logic [11:0] clr_q, clr_d, rgb_q, rgb_d, waddr, raddr;
  logic act1_q, hs1_q, vs1_q, oor1_q, act2_q, hs2_q, vs2_q;
  logic [3:0] vidx1_q;
  logic [2:0] hidx1_q;
  logic clearing, in_range, rd_en, wr_ok, we, lit;
  logic [7:0] wdata, rd_char;
  always_comb begin
    clearing = state_q == CLEAR;
    in_range = in_x < 10'(X_MAX) && in_y < 10'(Y_MAX);
    rd_en = in_active && in_range;
    raddr = cell_addr(in_y[9:VB], in_x[9:HB]);
    wr_ok = !clearing && wr_en && wr_col < 7'(COLS) && wr_row < 5'(ROWS);
    we = clearing || wr_ok;
    waddr = clearing ? clr_q : cell_addr({1'b0, wr_row}, wr_col);
    wdata = clearing ? BLANK_CHAR : wr_char;
    clr_d = clearing ? clr_q + 12'd1 : '0;
    state_d = clearing && clr_q == 12'(BUF_DEPTH - 1) ? RUN : state_q;
    rgb_d = !act1_q || clearing ? '0 : !oor1_q && lit ? FG_COLOR : BG_COLOR;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_q <= '0;
      act1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      oor1_q <= 1'b0;
      vidx1_q <= '0;
      hidx1_q <= '0;
      rgb_q <= '0;
      act2_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      act1_q <= in_active;
      hs1_q <= in_hsync;
      vs1_q <= in_vsync;
      oor1_q <= !in_range;
      vidx1_q <= in_y[VB-1:0];
      hidx1_q <= in_x[HB-1:0];
      rgb_q <= rgb_d;
      act2_q <= act1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end
  text_buffer u_buf (
    .clk(clk), .we(we), .waddr(waddr), .wdata(wdata),
    .re(rd_en), .raddr(raddr), .rdata(rd_char)
  );
  char_lut u_lut (.ch(rd_char), .vidx(vidx1_q), .hidx(hidx1_q), .lit(lit));
  assign busy = clearing;
  assign wr_ready = !clearing;
  assign out_rgb = rgb_q;
  assign out_hsync = hs2_q;
  assign out_vsync = vs2_q;
  assign out_active = act2_q;
endmodule

// File: tb/tb_text_renderer.sv
// tb_text_renderer: random and directed stimulus checked each cycle against a screen-level model.
module tb_text_renderer;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
  logic clk = 0, rst = 1, in_active = 0, in_hsync = 0, in_vsync = 0, wr_en = 0;
  logic [9:0] in_x = 0, in_y = 0;
  logic [6:0] wr_col = 0;
  logic [4:0] wr_row = 0;
  logic [7:0] wr_char = 0;
  logic wr_ready, busy, out_hsync, out_vsync, out_active;
  logic [11:0] out_rgb;
  int errors = 0, checks = 0;
  bit chk_on = 0;
  text_renderer dut (
    .clk(clk), .rst(rst), .in_active(in_active), .in_x(in_x), .in_y(in_y),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .wr_en(wr_en), .wr_col(wr_col),
    .wr_row(wr_row), .wr_char(wr_char), .wr_ready(wr_ready), .busy(busy),
    .out_rgb(out_rgb), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_active(out_active)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Glyph rows, leftmost pixel in bit 7; every other code renders blank.
  logic [7:0] ga [16] = '{8'h00, 8'h00, 8'h10, 8'h28, 8'h44, 8'h82, 8'h82, 8'hFE,
                          8'h82, 8'h82, 8'h82, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] gq [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3E, 8'h42,
                          8'h42, 8'h42, 8'h42, 8'h3E, 8'h02, 8'h02, 8'h02, 8'h00};
  function automatic bit glyph_lit(input logic [7:0] ch, input logic [3:0] v, input logic [2:0] h);
    logic [7:0] r;
    r = ch == 8'h41 ? ga[v] : ch == 8'h71 ? gq[v] : 8'h00;
    return r[7-h];
  endfunction
  logic [7:0] screen [2400];
  int clr = 0;
  logic s_act = 0, s_hs = 0, s_vs = 0, s_oor = 0;
  logic [7:0] s_ch = 0;
  logic [3:0] s_v = 0;
  logic [2:0] s_h = 0;
  logic [11:0] e_rgb = 0;
  logic e_hs = 0, e_vs = 0, e_act = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clr <= 0;
      {s_act, s_hs, s_vs, s_oor, s_ch, s_v, s_h} <= '0;
      {e_rgb, e_hs, e_vs, e_act} <= '0;
    end else begin
      e_act <= s_act;
      e_hs <= s_hs;
      e_vs <= s_vs;
      e_rgb <= (!s_act || clr < 2400) ? 12'h000 : (!s_oor && glyph_lit(s_ch, s_v, s_h)) ? FG : BG;
      s_act <= in_active;
      s_hs <= in_hsync;
      s_vs <= in_vsync;
      s_oor <= !(in_x < 640 && in_y < 480);
      s_v <= in_y[3:0];
      s_h <= in_x[2:0];
      if (in_active && in_x < 640 && in_y < 480) s_ch <= screen[(in_y / 16) * 80 + in_x / 8];
      if (clr < 2400) begin
        screen[clr] <= 8'h20;
        clr <= clr + 1;
      end else if (wr_en && wr_col < 80 && wr_row < 30) screen[wr_row * 80 + wr_col] <= wr_char;
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("rgb", out_rgb, e_rgb);
    chk("hsync", out_hsync, e_hs);
    chk("vsync", out_vsync, e_vs);
    chk("active", out_active, e_act);
    chk("busy", busy, int'(clr < 2400));
    chk("wr_ready", wr_ready, int'(clr >= 2400));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int col, input int row, input logic [7:0] ch);
    wr_en = 1;
    wr_col = 7'(col);
    wr_row = 5'(row);
    wr_char = ch;
    step();
    wr_en = 0;
  endtask
  task automatic probe(input int x, input int y, input logic [11:0] exp, input string name);
    in_active = 1;
    in_x = 10'(x);
    in_y = 10'(y);
    step();
    in_active = 0;
    step();
    chk(name, out_rgb, exp);
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
  endtask
  task automatic scan_row(input int y, output int fg);
    fg = 0;
    for (int x = 0; x < 640; x++) begin
      in_active = 1;
      in_x = 10'(x);
      in_y = 10'(y);
      step();
      if (out_rgb == FG) fg++;
    end
    in_active = 0;
    repeat (2) begin
      step();
      if (out_rgb == FG) fg++;
    end
  endtask
  initial begin
    int n, fg, r;
    repeat (3) step();
    chk_on = 1;
    step();
    chk("rst_rgb", out_rgb, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", wr_ready, 0);
    rst = 0;
    wait_idle(n);
    chk("clear_len", n, 2400);
    probe(0, 0, BG, "bg_0_0");
    probe(639, 479, BG, "bg_639_479");
    wr(0, 0, 8'h41);
    for (int x = 0; x < 8; x++) probe(x, 3, (x == 2 || x == 4) ? FG : BG, "A_row3");
    wr(79, 29, 8'h71);
    for (int x = 632; x < 640; x++) probe(x, 470, (x >= 634 && x <= 638) ? FG : BG, "q_y470");
    for (int x = 632; x < 640; x++) probe(x, 473, (x == 633 || x == 638) ? FG : BG, "q_y473");
    wr(0, 0, 8'h20);
    wr(80, 0, 8'h41);
    wr(5, 30, 8'h41);
    scan_row(3, fg);
    chk("row0_y3_fg", fg, 0);
    scan_row(7, fg);
    chk("row0_y7_fg", fg, 0);
    probe(2, 19, BG, "col80_no_wrap");
    probe(42, 467, BG, "row30_ignored");
    in_hsync = 1;
    for (int i = 0; i < 96; i++) begin
      step();
      if (i == 0) chk("hs_lag0", out_hsync, 0);
      if (i == 1) chk("hs_lag2", out_hsync, 1);
      if (i == 50) chk("hs_rgb0", out_rgb, 0);
    end
    in_hsync = 0;
    step();
    chk("hs_tail", out_hsync, 1);
    step();
    chk("hs_fall", out_hsync, 0);
    repeat (3000) begin
      in_active = $urandom_range(0, 3) != 0;
      in_x = 10'($urandom_range(0, 700));
      in_y = 10'($urandom_range(0, 520));
      in_hsync = 1'($urandom);
      in_vsync = 1'($urandom);
      wr_en = $urandom_range(0, 3) == 0;
      wr_col = 7'($urandom_range(0, 90));
      wr_row = 5'($urandom_range(0, 33));
      r = $urandom_range(0, 3);
      wr_char = r == 0 ? 8'h41 : r == 1 ? 8'h71 : r == 2 ? 8'h20 : 8'($urandom);
      step();
    end
    {in_active, in_hsync, in_vsync, wr_en} = '0;
    wr(0, 0, 8'h41);
    in_active = 1;
    in_x = 2;
    in_y = 3;
    step();
    step();
    chk("pre_rst_fg", out_rgb, FG);
    #1 rst = 1;
    #1;
    chk("mid_rst_rgb", out_rgb, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ready", wr_ready, 0);
    step();
    rst = 0;
    in_active = 0;
    wr(3, 0, 8'h41);
    wait_idle(n);
    chk("reclear_len", n, 2399);
    probe(2, 3, BG, "cell00_space");
    probe(26, 3, BG, "clear_write_dropped");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
